// File: rtl/voice_allocator_if.sv
// Note-request handshake between a sequencer (master) and the voice allocator (slave).
interface voice_allocator_if #(
    parameter int unsigned NOTE_W = 6,
    parameter int unsigned DUR_W  = 6
);
    logic              req_valid;
    logic [NOTE_W-1:0] req_note;
    logic [DUR_W-1:0]  req_duration;
    logic              req_ready;

    modport master (output req_valid, output req_note, output req_duration, input req_ready);
    modport slave  (input req_valid, input req_note, input req_duration, output req_ready);
endinterface

// File: rtl/voice_allocator.sv
// Three-voice note allocator: retriggers a voice already playing the requested note, otherwise
// claims the lowest idle voice; per-voice beat counters release voices when their notes expire.
module voice_allocator #(
    parameter int unsigned NOTE_W = 6,
    parameter int unsigned DUR_W  = 6
) (
    input  logic               clk,
    input  logic               reset,
    voice_allocator_if.slave   req,
    input  logic               beat,
    input  logic               flush,
    output logic [NOTE_W-1:0]  note_one,
    output logic [NOTE_W-1:0]  note_two,
    output logic [NOTE_W-1:0]  note_three,
    output logic [DUR_W-1:0]   duration_one,
    output logic [DUR_W-1:0]   duration_two,
    output logic [DUR_W-1:0]   duration_three,
    output logic               new_note_one,
    output logic               new_note_two,
    output logic               new_note_three,
    output logic [2:0]         voice_busy,
    output logic               all_idle
);

    localparam int NumVoices = 3;

    typedef enum logic {VoiceIdle, VoiceActive} voice_state_e;

    voice_state_e      state_q [NumVoices];
    voice_state_e      state_d [NumVoices];
    logic [DUR_W-1:0]  cnt_q   [NumVoices];
    logic [DUR_W-1:0]  cnt_d   [NumVoices];
    logic [NOTE_W-1:0] note_q  [NumVoices];
    logic [NOTE_W-1:0] note_d  [NumVoices];
    logic [DUR_W-1:0]  dur_q   [NumVoices];
    logic [DUR_W-1:0]  dur_d   [NumVoices];
    logic [NumVoices-1:0] pulse_q, pulse_d;

    logic [NumVoices-1:0] busy;
    logic [NumVoices-1:0] match;
    logic [NumVoices-1:0] load;
    logic                 is_rest;
    logic                 ready;
    logic                 accept;
    logic                 found;

    always_comb begin
        busy  = '0;
        match = '0;
        for (int i = 0; i < NumVoices; i++) begin
            busy[i]  = (state_q[i] == VoiceActive);
            match[i] = busy[i] && (note_q[i] == req.req_note);
        end
    end

    // Readiness looks only at registered state, so a voice freed this cycle is seen next cycle.
    assign is_rest       = (req.req_note == '0) || (req.req_duration == '0);
    assign ready         = !flush && (!(&busy) || (|match) || is_rest);
    assign accept        = req.req_valid && ready;
    assign req.req_ready = ready;

    always_comb begin
        load  = '0;
        found = 1'b0;
        if (accept && !is_rest) begin
            for (int i = 0; i < NumVoices; i++) begin
                if (!found && match[i]) begin
                    load[i] = 1'b1;
                    found   = 1'b1;
                end
            end
            for (int i = 0; i < NumVoices; i++) begin
                if (!found && !busy[i]) begin
                    load[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        note_d  = note_q;
        dur_d   = dur_q;
        pulse_d = '0;
        for (int i = 0; i < NumVoices; i++) begin
            if (flush) begin
                state_d[i] = VoiceIdle;
                cnt_d[i]   = '0;
            end else if (load[i]) begin
                // A load in a beat cycle takes precedence over the decrement.
                state_d[i] = VoiceActive;
                note_d[i]  = req.req_note;
                dur_d[i]   = req.req_duration;
                cnt_d[i]   = req.req_duration;
                pulse_d[i] = 1'b1;
            end else if (beat && busy[i]) begin
                cnt_d[i] = cnt_q[i] - DUR_W'(1);
                if (cnt_q[i] == DUR_W'(1)) begin
                    state_d[i] = VoiceIdle;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumVoices; i++) begin
                state_q[i] <= VoiceIdle;
                cnt_q[i]   <= '0;
                note_q[i]  <= '0;
                dur_q[i]   <= '0;
            end
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            pulse_q <= pulse_d;
        end
    end

    assign note_one       = note_q[0];
    assign note_two       = note_q[1];
    assign note_three     = note_q[2];
    assign duration_one   = dur_q[0];
    assign duration_two   = dur_q[1];
    assign duration_three = dur_q[2];
    assign new_note_one   = pulse_q[0];
    assign new_note_two   = pulse_q[1];
    assign new_note_three = pulse_q[2];
    assign voice_busy     = busy;
    assign all_idle       = ~|busy;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural voice-pool model.
module tb_voice_allocator;

    localparam int NW = 6;
    localparam int DW = 6;

    logic clk = 1'b0;
    logic reset;
    logic beat = 1'b0;
    logic flush = 1'b0;

    voice_allocator_if #(.NOTE_W(NW), .DUR_W(DW)) rif ();

    logic [NW-1:0] note_one, note_two, note_three;
    logic [DW-1:0] duration_one, duration_two, duration_three;
    logic          new_note_one, new_note_two, new_note_three;
    logic [2:0]    voice_busy;
    logic          all_idle;

    voice_allocator #(.NOTE_W(NW), .DUR_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (rif),
        .beat           (beat),
        .flush          (flush),
        .note_one       (note_one),
        .note_two       (note_two),
        .note_three     (note_three),
        .duration_one   (duration_one),
        .duration_two   (duration_two),
        .duration_three (duration_three),
        .new_note_one   (new_note_one),
        .new_note_two   (new_note_two),
        .new_note_three (new_note_three),
        .voice_busy     (voice_busy),
        .all_idle       (all_idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the voice pool: one entry per voice, plain integers.
    int m_active [3];
    int m_cnt    [3];
    int m_note   [3];
    int m_dur    [3];
    int m_pulse  [3];
    bit m_accepted;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int m_match();
        for (int i = 0; i < 3; i++)
            if (m_active[i] != 0 && m_note[i] == int'(rif.req_note)) return i;
        return -1;
    endfunction

    function automatic bit m_rest();
        return (rif.req_note == 0) || (rif.req_duration == 0);
    endfunction

    function automatic bit m_ready();
        int idle_cnt = 0;
        if (flush) return 1'b0;
        for (int i = 0; i < 3; i++) if (m_active[i] == 0) idle_cnt++;
        return (idle_cnt > 0) || (m_match() >= 0) || m_rest();
    endfunction

    always @(posedge clk or negedge reset) begin
        int na[3];
        int nc[3];
        int nn[3];
        int nd[3];
        int np[3];
        int tgt;
        bit acc;
        if (!reset) begin
            m_active   <= '{0, 0, 0};
            m_cnt      <= '{0, 0, 0};
            m_note     <= '{0, 0, 0};
            m_dur      <= '{0, 0, 0};
            m_pulse    <= '{0, 0, 0};
            m_accepted <= 1'b0;
        end else begin
            na  = m_active;
            nc  = m_cnt;
            nn  = m_note;
            nd  = m_dur;
            np  = '{0, 0, 0};
            acc = rif.req_valid && m_ready();
            if (flush) begin
                na = '{0, 0, 0};
                nc = '{0, 0, 0};
            end else begin
                tgt = -1;
                if (acc && !m_rest()) begin
                    tgt = m_match();
                    for (int i = 0; i < 3; i++)
                        if (tgt < 0 && m_active[i] == 0) tgt = i;
                end
                for (int i = 0; i < 3; i++) begin
                    if (i == tgt) begin
                        na[i] = 1;
                        nn[i] = int'(rif.req_note);
                        nd[i] = int'(rif.req_duration);
                        nc[i] = nd[i];
                        np[i] = 1;
                    end else if (beat && m_active[i] != 0) begin
                        nc[i] = m_cnt[i] - 1;
                        if (nc[i] == 0) na[i] = 0;
                    end
                end
            end
            m_active   <= na;
            m_cnt      <= nc;
            m_note     <= nn;
            m_dur      <= nd;
            m_pulse    <= np;
            m_accepted <= acc;
        end
    end

    always @(negedge clk) begin
        chk("note_one",       note_one,       m_note[0]);
        chk("note_two",       note_two,       m_note[1]);
        chk("note_three",     note_three,     m_note[2]);
        chk("duration_one",   duration_one,   m_dur[0]);
        chk("duration_two",   duration_two,   m_dur[1]);
        chk("duration_three", duration_three, m_dur[2]);
        chk("new_note_one",   new_note_one,   m_pulse[0]);
        chk("new_note_two",   new_note_two,   m_pulse[1]);
        chk("new_note_three", new_note_three, m_pulse[2]);
        chk("voice_busy",     voice_busy,     {m_active[2] != 0, m_active[1] != 0, m_active[0] != 0});
        chk("all_idle",       all_idle,       (m_active[0] | m_active[1] | m_active[2]) == 0);
        chk("req_ready",      rif.req_ready,  m_ready());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(bit v, int n, int d);
        rif.req_valid    = v;
        rif.req_note     = NW'(n);
        rif.req_duration = DW'(d);
    endtask

    initial begin
        set_req(0, 0, 0);
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_all_idle", all_idle, 1);
        chk("rst_busy", voice_busy, 0);
        chk("rst_note_one", note_one, 0);
        reset = 1'b1;

        // Single note, two beats to expire.
        set_req(1, 12, 2);
        #1 chk("s1_ready_first", rif.req_ready, 1);
        tick();
        set_req(0, 0, 0);
        chk("s1_pulse", new_note_one, 1);
        chk("s1_note", note_one, 12);
        chk("s1_dur", duration_one, 2);
        chk("s1_busy", voice_busy, 3'b001);
        beat = 1'b1;
        tick();
        chk("s1_busy_beat1", voice_busy, 3'b001);
        chk("s1_pulse_gone", new_note_one, 0);
        tick();
        beat = 1'b0;
        chk("s1_busy_beat2", voice_busy, 3'b000);
        chk("s1_note_held", note_one, 12);

        // Fill all voices, then a fourth note must wait.
        set_req(1, 5, 1);
        tick();
        set_req(1, 7, 4);
        tick();
        set_req(1, 9, 4);
        tick();
        set_req(1, 11, 5);
        #1;
        chk("s2_busy", voice_busy, 3'b111);
        chk("s2_n1", note_one, 5);
        chk("s2_n2", note_two, 7);
        chk("s2_n3", note_three, 9);
        chk("s2_ready_low", rif.req_ready, 0);
        beat = 1'b1;
        tick();
        beat = 1'b0;
        chk("s2_busy_freed", voice_busy, 3'b110);
        chk("s2_ready_high", rif.req_ready, 1);
        tick();
        set_req(0, 0, 0);
        chk("s2_pulse_v1", new_note_one, 1);
        chk("s2_note_v1", note_one, 11);

        // Retrigger voice 2 (note 7, 3 beats left).
        set_req(1, 7, 4);
        tick();
        set_req(0, 0, 0);
        chk("s3_pulses", {new_note_three, new_note_two, new_note_one}, 3'b010);
        chk("s3_dur2", duration_two, 4);
        chk("s3_busy", voice_busy, 3'b111);

        // Rests are accepted even with every voice busy.
        set_req(1, 0, 5);
        #1 chk("s4_ready_note0", rif.req_ready, 1);
        tick();
        chk("s4_pulses_note0", {new_note_three, new_note_two, new_note_one}, 0);
        set_req(1, 3, 0);
        #1 chk("s4_ready_dur0", rif.req_ready, 1);
        tick();
        set_req(0, 0, 0);
        chk("s4_pulses_dur0", {new_note_three, new_note_two, new_note_one}, 0);
        chk("s4_busy", voice_busy, 3'b111);

        // Flush with a pending request.
        flush = 1'b1;
        set_req(1, 13, 2);
        #1 chk("s5_ready", rif.req_ready, 0);
        tick();
        flush = 1'b0;
        set_req(0, 0, 0);
        chk("s5_busy", voice_busy, 0);
        chk("s5_pulses", {new_note_three, new_note_two, new_note_one}, 0);

        // Load with duration 1 in a beat cycle: no decrement that cycle.
        set_req(1, 20, 1);
        beat = 1'b1;
        tick();
        set_req(0, 0, 0);
        beat = 1'b0;
        chk("s6_busy_load", voice_busy, 3'b001);
        tick();
        chk("s6_busy_hold", voice_busy, 3'b001);
        beat = 1'b1;
        tick();
        beat = 1'b0;
        chk("s6_busy_done", voice_busy, 0);

        // Reset in the middle of a note.
        set_req(1, 30, 9);
        tick();
        set_req(0, 0, 0);
        chk("s7_pulse", new_note_one, 1);
        #2 reset = 1'b0;
        #1;
        chk("s7_note", note_one, 0);
        chk("s7_dur", duration_one, 0);
        chk("s7_busy", voice_busy, 0);
        chk("s7_idle", all_idle, 1);
        chk("s7_pulse_cleared", new_note_one, 0);
        tick();
        reset = 1'b1;

        // Random traffic; a refused request is held until accepted.
        for (int c = 0; c < 4000; c++) begin
            if (!(rif.req_valid && !m_accepted)) begin
                rif.req_valid    = ($urandom_range(0, 1) == 1);
                rif.req_note     = NW'($urandom_range(0, 9));
                rif.req_duration = DW'($urandom_range(0, 5));
            end
            beat  = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 24) == 0);
            reset = !($urandom_range(0, 399) == 0);
            tick();
        end

        set_req(0, 0, 0);
        beat  = 1'b0;
        flush = 1'b0;
        reset = 1'b1;
        tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NOTE_W, default 6, width of note codes.
REQ-002 SHALL have parameter DUR_W, default 6, width of durations in beats.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  note request present.
REQ-006 SHALL have port req_note  input  NOTE_W  requested note; 0 = rest.
REQ-007 SHALL have port req_duration  input  DUR_W  note length in beats.
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-009 SHALL have port beat  input  1  one-cycle beat strobe.
REQ-010 SHALL have port flush  input  1  release all voices.
REQ-011 SHALL have ports note_one, note_two, note_three  output  NOTE_W each  note assigned to voice 1/2/3.
REQ-012 SHALL have ports duration_one, duration_two, duration_three  output  DUR_W each  duration assigned to voice 1/2/3.
REQ-013 SHALL have ports new_note_one, new_note_two, new_note_three  output  1 each  one-cycle start pulse per voice.
REQ-014 SHALL have port voice_busy  output  3  bit i = voice i+1 ACTIVE.
REQ-015 SHALL have port all_idle  output  1  high when voice_busy == 0.

Function
REQ-016 SHALL keep per voice a state (IDLE/ACTIVE) and a DUR_W remaining-beat counter.
REQ-017 SHALL drive req_ready = !flush && (any voice IDLE || req_note matches an ACTIVE voice's note || req_note == 0 || req_duration == 0), all evaluated on registered state.
REQ-018 SHALL treat an accepted request with req_note == 0 or req_duration == 0 as a rest: accepted, no voice changes, no pulse.
REQ-019 SHALL, on an accepted non-rest request matching an ACTIVE voice's note (lowest index if several), retrigger that voice: reload counter and duration output, pulse its new_note.
REQ-020 SHALL otherwise allocate the lowest-index IDLE voice: latch note/duration outputs, load counter with req_duration, set ACTIVE, pulse its new_note.
REQ-021 SHALL assert new_note_x exactly one cycle, in the cycle after acceptance, coincident with the updated note_x/duration_x.
REQ-022 SHALL decrement each ACTIVE counter by 1 on every beat cycle, except a voice loaded or retriggered that same cycle (load wins, no decrement).
REQ-023 SHALL set a voice IDLE when beat occurs with its counter == 1; the freed voice is not visible to req_ready until the following cycle.
REQ-024 SHALL hold note_x/duration_x at their last values after a voice goes IDLE.
REQ-025 SHALL, on flush, set all voices IDLE and counters 0 next cycle, accept no request that cycle, and suppress all new_note pulses.
REQ-026 SHALL accept at most one request per cycle; when req_ready is low, req_valid/req_note/req_duration are held by the source.

Reset
REQ-027 SHALL, while reset is low, asynchronously clear all states to IDLE, counters to 0, note_x and duration_x to 0, new_note_x to 0, voice_busy to 0, and all_idle to 1.
REQ-028 SHALL make req_ready depend only on registered state after reset release (high on the first cycle if no flush).
REQ-029 SHALL, on reset asserted mid-note, drop all active notes with no pulses emitted.

Verification
REQ-030 SHALL cover: request note 12 dur 2, then two beats -> new_note_one pulse next cycle, note_one=12, duration_one=2, voice_busy=001, then 000 after the second beat.
REQ-031 SHALL cover: notes 5, 7, 9 on consecutive cycles, then a request for note 11 -> voices 1/2/3 get 5/7/9, voice_busy=111, req_ready low for note 11 until the first voice frees.
REQ-032 SHALL cover: voice 2 ACTIVE with note 7 and 3 beats left, request note 7 dur 4 -> new_note_two pulse, duration_two=4, no other voice allocated.
REQ-033 SHALL cover: requests with note 0 and with dur 0 -> both accepted, no pulses, voice_busy unchanged.
REQ-034 SHALL cover: beat in the same cycle as allocating voice 1 with dur 1 -> voice 1 stays ACTIVE until the next beat.
REQ-035 SHALL cover: flush with three voices ACTIVE and req_valid high -> req_ready low, voice_busy=000 next cycle, no new_note pulses; reset low mid-note -> all outputs at reset values immediately.
